dmp_domain_checker: RTL and testbench

DMP_DOMAIN_CHECKER -- requirements
Module: dmp_domain_checker

---
 rtl/dmp_domain_checker.sv | 194 +++++++++++++++++++
 tb/tb_dmp_domain_checker.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmp_domain_checker.sv
// dmp_domain_checker
//   Checks physical accesses against a small table of TOR (top-of-range)
//   regions. Each region is tagged with a domain id. A domain-switch FSM
//   drains any outstanding check before it changes the current domain.
//
// Ports
//   clk_i, rst_ni                 clock; asynchronous active-low reset
//   cfg_we_i/cfg_idx_i/cfg_wdata_i    entry {locked, domain} write
//   addr_we_i/addr_idx_i/addr_wdata_i entry TOR upper bound write (word units)
//   req_valid_i/req_ready_o/req_addr_i/priv_lvl_i   check request
//   resp_valid_o/resp_ready_i/resp_allow_o/resp_domain_o  check response
//   sw_req_i/sw_domain_i/sw_ack_o/sw_err_o  domain-switch handshake
//   cur_domain_o                  current domain register
module dmp_domain_checker #(
  parameter int NR_ENTRIES = 8,
  parameter int DOM_W      = 2,
  parameter int PLEN       = 34,
  localparam int IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [DOM_W:0]   cfg_wdata_i,
  input  logic             addr_we_i,
  input  logic [IDX_W-1:0] addr_idx_i,
  input  logic [PLEN-3:0]  addr_wdata_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_addr_i,
  input  logic [1:0]       priv_lvl_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_allow_o,
  output logic [DOM_W-1:0] resp_domain_o,
  input  logic             sw_req_i,
  input  logic [DOM_W-1:0] sw_domain_i,
  output logic             sw_ack_o,
  output logic             sw_err_o,
  output logic [DOM_W-1:0] cur_domain_o
);

  localparam logic [DOM_W-1:0] DOMI = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SWITCH} sw_state_e;

  logic [NR_ENTRIES-1:0] ent_lock_q, ent_lock_d;
  logic [DOM_W-1:0]      ent_dom_q [NR_ENTRIES];
  logic [DOM_W-1:0]      ent_dom_d [NR_ENTRIES];
  logic [PLEN-3:0]       ent_hi_q  [NR_ENTRIES];
  logic [PLEN-3:0]       ent_hi_d  [NR_ENTRIES];

  sw_state_e        state_q, state_d;
  logic [DOM_W-1:0] target_q, target_d;
  logic [DOM_W-1:0] cur_domain_q, cur_domain_d;
  logic             sw_ack_q, sw_ack_d;
  logic             sw_err_q, sw_err_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_allow_q, resp_allow_d;
  logic [DOM_W-1:0] resp_domain_q, resp_domain_d;

  logic [PLEN-3:0]  req_word;
  logic [PLEN-3:0]  lo_bound;
  logic             match;
  logic [DOM_W-1:0] match_dom;
  logic             chk_allow;
  logic             req_ready;
  logic             accept;
  logic             unused_addr_bits;

  assign req_word         = req_addr_i[PLEN-1:2];
  assign unused_addr_bits = ^req_addr_i[1:0];

  // Entry table writes; a locked entry ignores both kinds of write.
  always_comb begin
    ent_lock_d = ent_lock_q;
    ent_dom_d  = ent_dom_q;
    ent_hi_d   = ent_hi_q;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (cfg_we_i && (cfg_idx_i == IDX_W'(i)) && !ent_lock_q[i]) begin
        ent_lock_d[i] = cfg_wdata_i[DOM_W];
        ent_dom_d[i]  = cfg_wdata_i[DOM_W-1:0];
      end
      if (addr_we_i && (addr_idx_i == IDX_W'(i)) && !ent_lock_q[i]) begin
        ent_hi_d[i] = addr_wdata_i;
      end
    end
  end

  // Lowest-index match wins. The lower bound of entry i is the upper bound of
  // entry i-1, so an entry whose bound does not exceed its predecessor's can
  // never satisfy lo <= word < hi and is naturally empty.
  always_comb begin
    match     = 1'b0;
    match_dom = '0;
    lo_bound  = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (!match && (req_word >= lo_bound) && (req_word < ent_hi_q[i])) begin
        match     = 1'b1;
        match_dom = ent_dom_q[i];
      end
      lo_bound = ent_hi_q[i];
    end
  end

  assign chk_allow = (priv_lvl_i == 2'b11) ||
                     (match && ((match_dom == cur_domain_q) || (match_dom == DOMI)));

  assign req_ready = (!resp_valid_q || resp_ready_i) && (state_q == S_IDLE);
  assign accept    = req_valid_i && req_ready;

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_allow_d  = resp_allow_q;
    resp_domain_d = resp_domain_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_allow_d  = chk_allow;
      resp_domain_d = match_dom;
    end else if (resp_ready_i) begin
      resp_valid_d  = 1'b0;
    end
  end

  // Switch FSM. A request is ignored in the cycle its ack/err pulse is
  // visible, giving the requester that cycle to drop the level request.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cur_domain_d = cur_domain_q;
    sw_ack_d     = 1'b0;
    sw_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sw_req_i && !sw_ack_q && !sw_err_q) begin
          if (sw_domain_i == DOMI) begin
            sw_err_d = 1'b1;
          end else begin
            target_d = sw_domain_i;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!resp_valid_q || resp_ready_i) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        cur_domain_d = target_q;
        sw_ack_d     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_lock_q    <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        ent_dom_q[i] <= '0;
        ent_hi_q[i]  <= '0;
      end
      state_q       <= S_IDLE;
      target_q      <= '0;
      cur_domain_q  <= '0;
      sw_ack_q      <= 1'b0;
      sw_err_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_allow_q  <= 1'b0;
      resp_domain_q <= '0;
    end else begin
      ent_lock_q    <= ent_lock_d;
      ent_dom_q     <= ent_dom_d;
      ent_hi_q      <= ent_hi_d;
      state_q       <= state_d;
      target_q      <= target_d;
      cur_domain_q  <= cur_domain_d;
      sw_ack_q      <= sw_ack_d;
      sw_err_q      <= sw_err_d;
      resp_valid_q  <= resp_valid_d;
      resp_allow_q  <= resp_allow_d;
      resp_domain_q <= resp_domain_d;
    end
  end

  assign req_ready_o   = req_ready;
  assign resp_valid_o  = resp_valid_q;
  assign resp_allow_o  = resp_allow_q;
  assign resp_domain_o = resp_domain_q;
  assign sw_ack_o      = sw_ack_q;
  assign sw_err_o      = sw_err_q;
  assign cur_domain_o  = cur_domain_q;

endmodule

// File: tb/tb_dmp_domain_checker.sv
module tb_dmp_domain_checker;
  localparam int NR    = 8;
  localparam int DOM_W = 2;
  localparam int PLEN  = 34;
  localparam int IDX_W = 3;
  localparam logic [DOM_W-1:0] DOMI = 2'b11;
  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_M = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_we = 0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic [DOM_W:0]   cfg_wdata = '0;
  logic             addr_we = 0;
  logic [IDX_W-1:0] addr_idx = '0;
  logic [PLEN-3:0]  addr_wdata = '0;
  logic             req_valid = 0;
  logic             req_ready_o;
  logic [PLEN-1:0]  req_addr = '0;
  logic [1:0]       priv = '0;
  logic             resp_valid_o;
  logic             resp_ready = 1;
  logic             resp_allow_o;
  logic [DOM_W-1:0] resp_domain_o;
  logic             sw_req = 0;
  logic [DOM_W-1:0] sw_dom = '0;
  logic             sw_ack_o, sw_err_o;
  logic [DOM_W-1:0] cur_domain_o;

  int total = 0;
  int bad   = 0;

  dmp_domain_checker #(.NR_ENTRIES(NR), .DOM_W(DOM_W), .PLEN(PLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_wdata_i(cfg_wdata),
    .addr_we_i(addr_we), .addr_idx_i(addr_idx), .addr_wdata_i(addr_wdata),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .priv_lvl_i(priv),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_allow_o(resp_allow_o), .resp_domain_o(resp_domain_o),
    .sw_req_i(sw_req), .sw_domain_i(sw_dom), .sw_ack_o(sw_ack_o), .sw_err_o(sw_err_o),
    .cur_domain_o(cur_domain_o)
  );

  // Reference model: region table and current domain as plain arrays.
  longint           m_hi   [NR];
  logic [DOM_W-1:0] m_dom  [NR];
  bit               m_lock [NR];
  logic [DOM_W-1:0] m_cur;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) begin
      m_hi[i] = 0; m_dom[i] = '0; m_lock[i] = 0;
    end
    m_cur = '0;
  endfunction

  function automatic void model(input logic [PLEN-1:0] a, input logic [1:0] p,
                                output logic al, output logic [DOM_W-1:0] d);
    longint w, lo, up;
    int hit;
    w = longint'(a) / 4;
    hit = -1;
    for (int i = 0; i < NR; i++) begin
      if (i == 0) lo = 0; else lo = m_hi[i-1];
      up = m_hi[i];
      if (hit < 0 && lo < up && w >= lo && w < up) hit = i;
    end
    d  = (hit >= 0) ? m_dom[hit] : '0;
    al = (p == PRV_M) || (hit >= 0 && (m_dom[hit] == m_cur || m_dom[hit] == DOMI));
  endfunction

  function automatic logic [PLEN-1:0] waddr(input longint w);
    return PLEN'(w * 4);
  endfunction

  task automatic cfg_write(input int idx, input bit lk, input logic [DOM_W-1:0] d);
    cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_wdata = {lk, d};
    @(posedge clk); #1;
    cfg_we = 0;
    if (!m_lock[idx]) begin m_lock[idx] = lk; m_dom[idx] = d; end
  endtask

  task automatic addr_write(input int idx, input longint hi);
    addr_we = 1; addr_idx = IDX_W'(idx); addr_wdata = (PLEN-2)'(hi);
    @(posedge clk); #1;
    addr_we = 0;
    if (!m_lock[idx]) m_hi[idx] = hi;
  endtask

  task automatic do_req(input logic [PLEN-1:0] a, input logic [1:0] p,
                        output logic al, output logic [DOM_W-1:0] d, output bit ok);
    int n = 0;
    req_addr = a; priv = p; req_valid = 1; resp_ready = 1;
    #1;
    while (req_ready_o !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 0;
    ok = (resp_valid_o === 1'b1) && (n < 20);
    al = resp_allow_o; d = resp_domain_o;
    @(posedge clk); #1;
  endtask

  task automatic do_switch(input logic [DOM_W-1:0] t, output bit ack, output bit err);
    int n = 0;
    sw_req = 1; sw_dom = t; ack = 0; err = 0;
    while (!ack && !err && n < 20) begin
      @(posedge clk); #1; n++;
      ack = sw_ack_o; err = sw_err_o;
    end
    sw_req = 0;
    if (ack) m_cur = t;
  endtask

  task automatic test_reset;
    m_reset();
    #12;
    total++;
    if (resp_valid_o !== 0 || resp_allow_o !== 0 || resp_domain_o !== 0 ||
        sw_ack_o !== 0 || sw_err_o !== 0 || cur_domain_o !== 0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b allow=%b dom=%0d ack=%b err=%b cur=%0d want all 0",
               resp_valid_o, resp_allow_o, resp_domain_o, sw_ack_o, sw_err_o, cur_domain_o);
    end
    rst_n = 1;
    @(posedge clk); #1;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_basic;
    logic al, eal; logic [DOM_W-1:0] d, ed; bit ok, ack, err;
    cfg_write(0, 0, 2'd1);
    addr_write(0, 'h100);
    model(waddr('h80), PRV_U, eal, ed);
    do_req(waddr('h80), PRV_U, al, d, ok);
    total++;
    if (!ok || al !== 1'b0 || d !== 2'd1 || al !== eal || d !== ed) begin
      bad++; $display("FAIL basic_deny: ok=%b allow=%b dom=%0d want allow=0 dom=1", ok, al, d);
    end
    do_switch(2'd1, ack, err);
    total++;
    if (!ack || err || cur_domain_o !== 2'd1) begin
      bad++; $display("FAIL basic_switch: ack=%b err=%b cur=%0d want ack cur=1", ack, err, cur_domain_o);
    end
    @(posedge clk); #1;
    total++;
    if (sw_ack_o !== 1'b0) begin
      bad++; $display("FAIL ack_pulse_width: ack=%b want 0", sw_ack_o);
    end
    model(waddr('h80), PRV_U, eal, ed);
    do_req(waddr('h80), PRV_U, al, d, ok);
    total++;
    if (!ok || al !== 1'b1 || al !== eal || d !== ed) begin
      bad++; $display("FAIL basic_allow: ok=%b allow=%b dom=%0d want allow=1 dom=1", ok, al, d);
    end
  endtask

  task automatic test_domi;
    logic al, eal; logic [DOM_W-1:0] d, ed; bit ok, ack, err;
    cfg_write(1, 0, DOMI);
    addr_write(1, 'h200);
    do_switch(2'd2, ack, err);
    total++;
    if (!ack || cur_domain_o !== 2'd2) begin
      bad++; $display("FAIL domi_switch: ack=%b cur=%0d want ack cur=2", ack, cur_domain_o);
    end
    model(waddr('h150), PRV_U, eal, ed);
    do_req(waddr('h150), PRV_U, al, d, ok);
    total++;
    if (!ok || al !== 1'b1 || d !== DOMI || al !== eal || d !== ed) begin
      bad++; $display("FAIL domi_allow: allow=%b dom=%0d want allow=1 dom=3", al, d);
    end
    model(waddr('h250), PRV_U, eal, ed);
    do_req(waddr('h250), PRV_U, al, d, ok);
    total++;
    if (!ok || al !== 1'b0 || d !== 2'd0 || al !== eal || d !== ed) begin
      bad++; $display("FAIL nomatch_u_deny: allow=%b dom=%0d want allow=0 dom=0", al, d);
    end
    model(waddr('h250), PRV_M, eal, ed);
    do_req(waddr('h250), PRV_M, al, d, ok);
    total++;
    if (!ok || al !== 1'b1 || d !== 2'd0 || al !== eal || d !== ed) begin
      bad++; $display("FAIL nomatch_m_allow: allow=%b dom=%0d want allow=1 dom=0", al, d);
    end
  endtask

  task automatic test_lock;
    logic al, eal; logic [DOM_W-1:0] d, ed; bit ok;
    cfg_write(0, 1, 2'd1);
    cfg_write(0, 0, 2'd2);
    addr_write(0, 'h300);
    model(waddr('h80), PRV_U, eal, ed);
    do_req(waddr('h80), PRV_U, al, d, ok);
    total++;
    if (!ok || d !== 2'd1 || al !== 1'b0 || al !== eal || d !== ed) begin
      bad++; $display("FAIL lock_cfg: allow=%b dom=%0d want allow=0 dom=1", al, d);
    end
    model(waddr('h150), PRV_U, eal, ed);
    do_req(waddr('h150), PRV_U, al, d, ok);
    total++;
    if (!ok || d !== DOMI || al !== eal || d !== ed) begin
      bad++; $display("FAIL lock_hi: allow=%b dom=%0d want dom=3 (entry0 bound unchanged)", al, d);
    end
  endtask

  task automatic test_err;
    int errs = 0; bit drop = 0;
    sw_req = 1; sw_dom = DOMI; resp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (sw_err_o === 1'b1) begin errs++; sw_req = 0; end
      if (req_ready_o !== 1'b1) drop = 1;
    end
    sw_req = 0;
    total++;
    if (errs != 1 || sw_ack_o !== 1'b0) begin
      bad++; $display("FAIL err_pulse: err_cycles=%0d ack=%b want 1 and 0", errs, sw_ack_o);
    end
    total++;
    if (drop || cur_domain_o !== m_cur) begin
      bad++; $display("FAIL err_side_effects: ready_dropped=%b cur=%0d want 0 and %0d", drop, cur_domain_o, m_cur);
    end
  endtask

  task automatic test_drain;
    logic eal; logic [DOM_W-1:0] ed; bit ack, err;
    do_switch(2'd1, ack, err);
    total++;
    if (!ack || cur_domain_o !== 2'd1) begin
      bad++; $display("FAIL drain_pre_switch: ack=%b cur=%0d want ack cur=1", ack, cur_domain_o);
    end
    @(posedge clk); #1;
    model(waddr('h80), PRV_U, eal, ed);
    resp_ready = 0; req_valid = 1; req_addr = waddr('h80); priv = PRV_U;
    @(posedge clk); #1;
    req_valid = 0;
    sw_req = 1; sw_dom = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready_o !== 0 || sw_ack_o !== 0 || cur_domain_o !== 2'd1 ||
          resp_valid_o !== 1 || resp_allow_o !== eal || resp_domain_o !== ed) begin
        bad++;
        $display("FAIL drain_hold%0d: ready=%b ack=%b cur=%0d valid=%b allow=%b dom=%0d want 0 0 1 1 %b %0d",
                 k, req_ready_o, sw_ack_o, cur_domain_o, resp_valid_o, resp_allow_o, resp_domain_o, eal, ed);
      end
    end
    resp_ready = 1;
    @(posedge clk); #1;
    total++;
    if (resp_valid_o !== 0 || sw_ack_o !== 0 || req_ready_o !== 0) begin
      bad++; $display("FAIL drain_handshake: valid=%b ack=%b ready=%b want 0 0 0", resp_valid_o, sw_ack_o, req_ready_o);
    end
    @(posedge clk); #1;
    total++;
    if (sw_ack_o !== 1 || cur_domain_o !== 2'd2) begin
      bad++; $display("FAIL drain_ack: ack=%b cur=%0d want 1 and 2", sw_ack_o, cur_domain_o);
    end
    sw_req = 0; m_cur = 2'd2;
    @(posedge clk); #1;
    do_switch(2'd2, ack, err);
    total++;
    if (!ack || err || cur_domain_o !== 2'd2) begin
      bad++; $display("FAIL same_domain_switch: ack=%b err=%b cur=%0d want ack cur=2", ack, err, cur_domain_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle;
    logic al, eal; logic [DOM_W-1:0] d, ed; bit ok;
    addr_write(2, 'h300);
    cfg_write(2, 0, 2'd2);
    model(waddr('h250), PRV_U, eal, ed);
    req_valid = 1; req_addr = waddr('h250); priv = PRV_U; resp_ready = 1;
    cfg_we = 1; cfg_idx = 3'd2; cfg_wdata = {1'b0, 2'd0};
    @(posedge clk); #1;
    req_valid = 0; cfg_we = 0;
    m_dom[2] = 2'd0;
    total++;
    if (resp_valid_o !== 1 || resp_allow_o !== eal || resp_domain_o !== ed) begin
      bad++; $display("FAIL same_cycle_prewrite: valid=%b allow=%b dom=%0d want 1 %b %0d",
                      resp_valid_o, resp_allow_o, resp_domain_o, eal, ed);
    end
    @(posedge clk); #1;
    model(waddr('h250), PRV_U, eal, ed);
    do_req(waddr('h250), PRV_U, al, d, ok);
    total++;
    if (!ok || al !== eal || d !== ed) begin
      bad++; $display("FAIL same_cycle_postwrite: allow=%b dom=%0d want %b %0d", al, d, eal, ed);
    end
  endtask

  task automatic test_back_to_back;
    logic [PLEN-1:0] a [10];
    logic [1:0]      p [10];
    logic eal; logic [DOM_W-1:0] ed;
    for (int i = 0; i < 10; i++) begin
      a[i] = waddr(longint'($urandom_range(0, 'h340)));
      p[i] = 2'($urandom_range(0, 3));
    end
    resp_ready = 1; req_valid = 1; req_addr = a[0]; priv = p[0];
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      model(a[i], p[i], eal, ed);
      total++;
      if (resp_valid_o !== 1 || resp_allow_o !== eal || resp_domain_o !== ed) begin
        bad++; $display("FAIL b2b_%0d: valid=%b allow=%b dom=%0d want 1 %b %0d",
                        i, resp_valid_o, resp_allow_o, resp_domain_o, eal, ed);
      end
      if (i < 9) begin req_addr = a[i+1]; priv = p[i+1]; end
      else req_valid = 0;
    end
    @(posedge clk); #1;
    total++;
    if (resp_valid_o !== 0) begin
      bad++; $display("FAIL b2b_clear: valid=%b want 0", resp_valid_o);
    end
  endtask

  task automatic test_random;
    logic al, eal; logic [DOM_W-1:0] d, ed, t; bit ok, ack, err;
    logic [PLEN-1:0] a; logic [1:0] p;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0: cfg_write(int'($urandom_range(0, NR-1)), ($urandom_range(0, 15) == 0), DOM_W'($urandom));
        1, 2: addr_write(int'($urandom_range(0, NR-1)), longint'($urandom_range(0, 'h50)) * 16);
        3: begin
          t = DOM_W'($urandom);
          do_switch(t, ack, err);
          total++;
          if (ack !== (t != DOMI) || err !== (t == DOMI) || cur_domain_o !== m_cur) begin
            bad++; $display("FAIL rand_switch%0d: target=%0d ack=%b err=%b cur=%0d want cur=%0d",
                            n, t, ack, err, cur_domain_o, m_cur);
          end
          @(posedge clk); #1;
        end
        default: begin
          a = PLEN'(longint'($urandom_range(0, 'h1500)));
          p = 2'($urandom_range(0, 3));
          model(a, p, eal, ed);
          do_req(a, p, al, d, ok);
          total++;
          if (!ok || al !== eal || d !== ed) begin
            bad++; $display("FAIL rand_req%0d: addr=%h priv=%0d ok=%b allow=%b dom=%0d want %b %0d",
                            n, a, p, ok, al, d, eal, ed);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_drain;
    logic al, eal; logic [DOM_W-1:0] d, ed; bit ok, late_ack = 0, not_ready = 0;
    resp_ready = 0; req_valid = 1; req_addr = waddr('h10); priv = PRV_U;
    @(posedge clk); #1;
    req_valid = 0;
    sw_req = 1; sw_dom = (m_cur == 2'd1) ? 2'd2 : 2'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    total++;
    if (resp_valid_o !== 0 || resp_allow_o !== 0 || resp_domain_o !== 0 ||
        sw_ack_o !== 0 || sw_err_o !== 0 || cur_domain_o !== 0) begin
      bad++; $display("FAIL reset_in_drain: valid=%b allow=%b dom=%0d ack=%b err=%b cur=%0d want all 0",
                      resp_valid_o, resp_allow_o, resp_domain_o, sw_ack_o, sw_err_o, cur_domain_o);
    end
    sw_req = 0; resp_ready = 1;
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (sw_ack_o !== 0) late_ack = 1;
      if (req_ready_o !== 1) not_ready = 1;
    end
    total++;
    if (late_ack || not_ready || cur_domain_o !== 0) begin
      bad++; $display("FAIL post_reset_idle: late_ack=%b not_ready=%b cur=%0d want 0 0 0",
                      late_ack, not_ready, cur_domain_o);
    end
    cfg_write(0, 0, 2'd2);
    addr_write(0, 'h100);
    model(waddr('h80), PRV_U, eal, ed);
    do_req(waddr('h80), PRV_U, al, d, ok);
    total++;
    if (!ok || d !== 2'd2 || al !== 1'b0 || al !== eal || d !== ed) begin
      bad++; $display("FAIL reset_clears_lock: allow=%b dom=%0d want allow=0 dom=2", al, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_domi();
    test_lock();
    test_err();
    test_drain();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
